// File: rtl/memio_pkg.sv
// memio_pkg: shared types and constants for the memio_responder block.
//   state_t        : responder FSM states
//   IO_*           : IO bank offsets, decoded on addr[1:0]
//   BAD_ADDR_DATA  : read data returned for an out-of-range RAM address
package memio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] IO_OUT     = 2'd0;
    localparam logic [1:0] IO_IN      = 2'd1;
    localparam logic [1:0] IO_SCRATCH = 2'd2;
    localparam logic [1:0] IO_CYCLES  = 2'd3;

    localparam logic [15:0] BAD_ADDR_DATA = 16'hDEAD;

endpackage

// File: rtl/memio_if.sv
// memio_if: CPU-side access bus between the CPU export port and memio_responder.
//   en, RW, MemIO, addr, data_write : request, driven by the CPU (master)
//   data_read, ready, busy, err     : response, driven by the responder (slave)
interface memio_if;

    logic        en;
    logic        RW;
    logic        MemIO;
    logic [15:0] addr;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output en, RW, MemIO, addr, data_write,
        input  data_read, ready, busy, err
    );

    modport slave (
        input  en, RW, MemIO, addr, data_write,
        output data_read, ready, busy, err
    );

endinterface

// File: rtl/memio_ram.sv
// memio_ram: single-port word RAM, DEPTH x 16, contents not reset.
//   clk   : clock
//   we    : write enable, write commits on the rising edge
//   addr  : word address
//   wdata : write data
//   rdata : read data for addr; the responder captures it into its
//           data_read register, which makes the read synchronous at the bus
module memio_ram #(
    parameter int DEPTH = 256,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memio_responder.sv
// memio_responder: services one CPU read/write per request from an internal
// word RAM (MemIO=0) or a four-entry IO bank (MemIO=1), then pulses ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : memio_if.slave request/response bus
//   io_in    : asynchronous external input, read through a 2-flop synchronizer
//   io_out   : external output register (IO offset 0)
// Build option: define MEMIO_ADDR_CHECK_EN to flag RAM addresses >= MEM_DEPTH
// with err (write suppressed, read returns BAD_ADDR_DATA); otherwise the RAM
// address wraps and err is tied low.
module memio_responder
    import memio_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int MEM_WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    memio_if.slave      bus,
    input  logic [15:0] io_in,
    output logic [15:0] io_out
);

    localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        enter_done;
    logic        addr_bad;
    logic        ram_we;

    logic        req_rw, req_memio;
    logic [15:0] req_addr, req_wdata;
    logic        cur_rw, cur_memio;
    logic [15:0] cur_addr, cur_wdata;

    logic [15:0] ram_rdata, io_rdata;
    logic [15:0] scratch, cycles, sync1, sync2, data_read_q;

    // IO and zero-wait RAM accesses complete on the acceptance edge itself,
    // so the commit logic works from the live bus in IDLE and from the
    // latched request otherwise.
    assign cur_rw    = (state == IDLE) ? bus.RW         : req_rw;
    assign cur_memio = (state == IDLE) ? bus.MemIO      : req_memio;
    assign cur_addr  = (state == IDLE) ? bus.addr       : req_addr;
    assign cur_wdata = (state == IDLE) ? bus.data_write : req_wdata;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        enter_done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    if (bus.MemIO || (MEM_WAIT == 0)) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            req_rw    <= 1'b0;
            req_memio <= 1'b0;
            req_addr  <= 16'd0;
            req_wdata <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == IDLE && bus.en) begin
                req_rw    <= bus.RW;
                req_memio <= bus.MemIO;
                req_addr  <= bus.addr;
                req_wdata <= bus.data_write;
            end
        end
    end

    always_comb begin
        case (cur_addr[1:0])
            IO_OUT:     io_rdata = io_out;
            IO_IN:      io_rdata = sync2;
            IO_SCRATCH: io_rdata = scratch;
            default:    io_rdata = cycles;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_out      <= 16'd0;
            scratch     <= 16'd0;
            cycles      <= 16'd0;
            sync1       <= 16'd0;
            sync2       <= 16'd0;
            data_read_q <= 16'd0;
        end else begin
            sync1  <= io_in;
            sync2  <= sync1;
            cycles <= cycles + 16'd1;
            if (enter_done) begin
                if (cur_memio) begin
                    if (cur_rw) begin
                        if (cur_addr[1:0] == IO_OUT) begin
                            io_out <= cur_wdata;
                        end else if (cur_addr[1:0] == IO_SCRATCH) begin
                            scratch <= cur_wdata;
                        end
                    end else begin
                        data_read_q <= io_rdata;
                    end
                end else if (!cur_rw) begin
                    data_read_q <= addr_bad ? BAD_ADDR_DATA : ram_rdata;
                end
            end
        end
    end

    assign ram_we = enter_done && !rst && !cur_memio && cur_rw && !addr_bad;

    memio_ram #(.DEPTH(MEM_DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_addr[AW-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

`ifdef MEMIO_ADDR_CHECK_EN
    logic err_q;

    assign addr_bad = ({1'b0, cur_addr} >= 17'(MEM_DEPTH));

    // DONE lasts exactly one cycle, so this register pulses alongside ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enter_done && !cur_memio && addr_bad;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^cur_addr;
    assign addr_bad         = 1'b0;
    assign bus.err          = 1'b0;
`endif

    assign bus.ready     = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.data_read = data_read_q;

endmodule

// File: tb/tb_memio_responder.sv
module tb_memio_responder;

    logic        clk;
    logic        rst;
    logic [15:0] io_in;
    logic [15:0] io_out;

    int n_assert = 0;
    int n_fail   = 0;

    memio_if bus ();

    memio_responder #(.MEM_DEPTH(256), .MEM_WAIT(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the responder idle. Returns the
    // cycle index (T0+n) in which ready was seen, plus what was on the bus then.
    task automatic do_req(input logic rw, input logic memio, input logic [15:0] a,
                          input logic [15:0] wd, output int lat,
                          output logic [15:0] rd, output logic e, output logic [15:0] io_o);
        bus.en         = 1'b1;
        bus.RW         = rw;
        bus.MemIO      = memio;
        bus.addr       = a;
        bus.data_write = wd;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        lat = 1;
        while (bus.ready !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd   = bus.data_read;
        e    = bus.err;
        io_o = io_out;
        @(posedge clk);
        #1;
        chk("ready_one_cycle", {31'd0, bus.ready}, 32'd0);
    endtask

    int          lat;
    logic [15:0] rd, io_o;
    logic        e;
    int          rdy_cnt;
    int          cyc;
    int          nrec;
    int          rec_cyc [3];
    logic [15:0] rec_dat [3];

    initial begin
        rst            = 1'b1;
        io_in          = 16'h0000;
        bus.en         = 1'b0;
        bus.RW         = 1'b0;
        bus.MemIO      = 1'b0;
        bus.addr       = 16'h0000;
        bus.data_write = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     {31'd0, bus.ready}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy},  32'd0);
        chk("rst_err",       {31'd0, bus.err},   32'd0);
        chk("rst_data_read", {16'd0, bus.data_read}, 32'd0);
        chk("rst_io_out",    {16'd0, io_out},    32'd0);

        // rst and en together: request must not be accepted
        bus.en = 1'b1; bus.MemIO = 1'b1; bus.RW = 1'b0; bus.addr = 16'h0003;
        @(posedge clk);
        #1;
        chk("rst_en_busy", {31'd0, bus.busy}, 32'd0);
        bus.en = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_en_no_ready", {31'd0, bus.ready}, 32'd0);

        // RAM write then read, MEM_WAIT=2 -> ready in cycle T0+3
        do_req(1'b1, 1'b0, 16'h0000, 16'hFFFF, lat, rd, e, io_o);
        chk("ram_wr_lat",       lat, 3);
        chk("ram_wr_keeps_rd",  {16'd0, rd}, 32'h0000);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, e, io_o);
        chk("ram_rd_lat",  lat, 3);
        chk("ram_rd_data", {16'd0, rd}, 32'hFFFF);
        chk("ram_rd_err",  {31'd0, e}, 32'd0);

        // rst during the first WAIT cycle drops a pending write
        do_req(1'b1, 1'b0, 16'h0007, 16'h1111, lat, rd, e, io_o);
        chk("ram_wr7_lat", lat, 3);
        bus.en = 1'b1; bus.RW = 1'b1; bus.MemIO = 1'b0;
        bus.addr = 16'h0007; bus.data_write = 16'h5555;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        chk("wait_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy",      {31'd0, bus.busy}, 32'd0);
        chk("midrst_data_read", {16'd0, bus.data_read}, 32'h0000);
        rdy_cnt = 0;
        repeat (5) begin
            if (bus.ready === 1'b1) rdy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("midrst_no_ready", rdy_cnt, 0);
        do_req(1'b0, 1'b0, 16'h0007, 16'h0000, lat, rd, e, io_o);
        chk("midrst_old_data", {16'd0, rd}, 32'h1111);

        // IO output register
        do_req(1'b1, 1'b1, 16'h0000, 16'h00A5, lat, rd, e, io_o);
        chk("io_wr_lat",    lat, 1);
        chk("io_out_ready", {16'd0, io_o}, 32'h00A5);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, lat, rd, e, io_o);
        chk("io_rd_lat",  lat, 1);
        chk("io_rd_out",  {16'd0, rd}, 32'h00A5);
        do_req(1'b0, 1'b1, 16'hFFFC, 16'h0000, lat, rd, e, io_o);
        chk("io_rd_hi_addr_ignored", {16'd0, rd}, 32'h00A5);

        // scratch register
        do_req(1'b1, 1'b1, 16'h0002, 16'h3C3C, lat, rd, e, io_o);
        chk("scratch_io_out_kept", {16'd0, io_o}, 32'h00A5);
        do_req(1'b0, 1'b1, 16'h0002, 16'h0000, lat, rd, e, io_o);
        chk("scratch_rd", {16'd0, rd}, 32'h3C3C);

        // io_in through the synchronizer; writes to it are ignored
        io_in = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        do_req(1'b0, 1'b1, 16'h0001, 16'h0000, lat, rd, e, io_o);
        chk("io_in_rd", {16'd0, rd}, 32'h1234);
        do_req(1'b1, 1'b1, 16'h0001, 16'h9999, lat, rd, e, io_o);
        chk("io_in_wr_keeps_rd", {16'd0, rd}, 32'h1234);
        chk("io_in_wr_io_out",   {16'd0, io_o}, 32'h00A5);
        do_req(1'b0, 1'b1, 16'h0001, 16'h0000, lat, rd, e, io_o);
        chk("io_in_ro", {16'd0, rd}, 32'h1234);

        // out-of-range RAM address: wraps by default, flagged when checked
        do_req(1'b1, 1'b0, 16'h0100, 16'hBEEF, lat, rd, e, io_o);
        chk("oor_wr_lat", lat, 3);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, e, io_o);
`ifdef MEMIO_ADDR_CHECK_EN
        chk("oor_wr_suppressed", {16'd0, rd}, 32'hFFFF);
`else
        chk("wrap_rd0", {16'd0, rd}, 32'hBEEF);
`endif
        chk("wrap_rd0_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 1'b0, 16'h0100, 16'h0000, lat, rd, e, io_o);
        chk("oor_rd_lat", lat, 3);
`ifdef MEMIO_ADDR_CHECK_EN
        chk("oor_rd_data", {16'd0, rd}, 32'hDEAD);
        chk("oor_rd_err",  {31'd0, e}, 32'd1);
`else
        chk("wrap_rd100",     {16'd0, rd}, 32'hBEEF);
        chk("wrap_rd100_err", {31'd0, e}, 32'd0);
`endif

        // en held high on an IO cycle-counter read: ready every 2 cycles
        bus.en = 1'b1; bus.RW = 1'b0; bus.MemIO = 1'b1; bus.addr = 16'h0003;
        cyc  = 0;
        nrec = 0;
        while (nrec < 3 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.ready === 1'b1) begin
                rec_cyc[nrec] = cyc;
                rec_dat[nrec] = bus.data_read;
                nrec++;
            end
        end
        bus.en = 1'b0;
        chk("held_pulses", nrec, 3);
        if (nrec == 3) begin
            chk("held_first_lat", rec_cyc[0], 1);
            chk("held_period_a", rec_cyc[1] - rec_cyc[0], 2);
            chk("held_period_b", rec_cyc[2] - rec_cyc[1], 2);
            chk("held_delta_a", {16'd0, rec_dat[1] - rec_dat[0]}, 32'd2);
            chk("held_delta_b", {16'd0, rec_dat[2] - rec_dat[1]}, 32'd2);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memio_responder.md
# memio_responder

Bus responder on the far end of the CPU_export access interface. Accepts one read or write per request (en/RW/MemIO/addr/data_write), services it from an internal word RAM or a small IO register bank, then returns data_read with a one-cycle ready pulse. Sits between the CPU-side export port and the memory/IO resources; the CPU is the only initiator.

## Interface
- MEM_DEPTH, 256: RAM words, power of two, at most 65536.
- MEM_WAIT, 2: wait cycles inserted on RAM accesses, 0 to 15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  request valid; sampled only in IDLE.
- RW  in  1  0 = read, 1 = write.
- MemIO  in  1  0 = RAM, 1 = IO bank.
- addr  in  16  word address.
- data_write  in  16  write data.
- data_read  out  16  read data; holds until the next read completes.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight (state != IDLE).
- io_in  in  16  external input port; asynchronous.
- io_out  out  16  external output register.
- err  out  1  address-error pulse, coincident with ready.

## Operation
- FSM states:
  - IDLE: if en=1, latch RW, MemIO, addr and data_write into request registers.
    - MemIO=1: go to DONE.
    - MemIO=0 and MEM_WAIT=0: go to DONE.
    - MemIO=0 otherwise: load wait counter with MEM_WAIT-1 and go to WAIT.
  - WAIT: decrement the counter; at 0 go to DONE.
  - DONE: ready=1; RAM write commits on the edge entering DONE; return to IDLE unconditionally.
- Inputs are ignored while busy. en held high re-issues the access every MEM_WAIT+2 cycles (RAM) or 2 cycles (IO).
- RAM: uses addr[log2(MEM_DEPTH)-1:0]. Synchronous read; read data is registered into data_read on the edge entering DONE.
- IO bank, decoded on addr[1:0]; addr[15:2] is ignored:
  - 0: io_out register, read/write.
  - 1: io_in through a 2-flop synchronizer, read-only.
  - 2: scratch register, read/write.
  - 3: free-running 16-bit cycle counter that wraps 0xFFFF to 0, read-only.
  - Writes to read-only locations are ignored without error.
- Writes leave data_read unchanged.

## Timing
- Acceptance edge is T0.
- IO access: ready high during cycle T0+1; io_out updates on the edge entering DONE.
- RAM access: ready high during cycle T0+MEM_WAIT+1.
- Next request is accepted at the earliest in the cycle after ready.
- Reset values: data_read=0, ready=0, busy=0, err=0, io_out=0, scratch=0, cycle counter=0, synchronizer=0, state IDLE. RAM contents are not reset.
- rst during WAIT: a pending write is dropped and no ready pulse is issued.
- rst and en high in the same cycle: reset wins and the request is not accepted.

## Configuration
- MEMIO_ADDR_CHECK_EN defined:
  - A RAM access with addr >= MEM_DEPTH completes with normal timing.
  - err=1 together with ready.
  - Writes are suppressed.
  - Reads return 16'hDEAD.
- MEMIO_ADDR_CHECK_EN undefined:
  - RAM address wraps modulo MEM_DEPTH.
  - err is tied to 0.

## Structure
- Package memio_pkg holds:
  - state enum {IDLE, WAIT, DONE};
  - IO offset constants IO_OUT=0, IO_IN=1, IO_SCRATCH=2, IO_CYCLES=3;
  - BAD_ADDR_DATA=16'hDEAD.
- Sub-module memio_ram: single-port synchronous RAM with parameter DEPTH, ports clk, we, addr, wdata, rdata.
- FSM, IO bank and synchronizer stay in the top module.

## Test plan
- RAM write then read (MEM_WAIT=2): write 16'hFFFF to addr 0, then read addr 0 → ready 3 cycles after each acceptance; data_read=16'hFFFF.
- IO output: write 16'h00A5 to IO offset 0 → io_out=16'h00A5 in the cycle ready is high; a read of offset 0 returns 16'h00A5.
- IO input sync: set io_in=16'h1234, wait 2 cycles, read IO offset 1 → data_read=16'h1234; a write to offset 1 leaves it unchanged.
- rst mid-WAIT: write 16'h5555 to addr 7 and assert rst in the first WAIT cycle → no ready pulse; a later read of addr 7 returns the old contents.
- Addr check, built with MEMIO_ADDR_CHECK_EN and MEM_DEPTH=256: read addr 16'h0100 → err and ready high together, data_read=16'hDEAD.
- Addr wrap, built without the macro: write 16'hBEEF to addr 16'h0100, read addr 0 → data_read=16'hBEEF, err=0.
- Held en: keep en=1 with an IO read of offset 3 → ready every 2 cycles; successive data_read values increase by 2.
